// File: rtl/medidor_pwm_pkg.sv
// Shared definitions for the servo PWM link (generator and meter side).
// Holds the FSM state encoding, the default nominal high times for the four
// position codes, the nominal period and the acceptance windows.
package medidor_pwm_pkg;

  typedef enum logic [1:0] {
    INICIAL = 2'b00,
    ALTO    = 2'b01,
    BAIXO   = 2'b10
  } estado_t;

  localparam logic [31:0] CONF_PERIODO_PADRAO   = 32'd1_000_000;
  localparam logic [31:0] LARGURA_000_PADRAO    = 32'd56_250;
  localparam logic [31:0] LARGURA_001_PADRAO    = 32'd68_750;
  localparam logic [31:0] LARGURA_010_PADRAO    = 32'd81_250;
  localparam logic [31:0] LARGURA_011_PADRAO    = 32'd93_750;
  localparam logic [31:0] TOLERANCIA_PADRAO     = 32'd6_250;
  localparam logic [31:0] TOL_PERIODO_PADRAO    = 32'd50_000;
  localparam logic [31:0] LIMITE_TIMEOUT_PADRAO = 32'd2_000_000;

  // Strict window test: |medido - nominal| < tol
  function automatic logic dentro_janela(input logic [31:0] medido,
                                         input logic [31:0] nominal,
                                         input logic [31:0] tol);
    logic [31:0] dif;
    dif = (medido > nominal) ? (medido - nominal) : (nominal - medido);
    return (dif < tol);
  endfunction

endpackage

// File: rtl/medidor_pwm_if.sv
// Signal bundle between the PWM meter and its users.
//   pwm_in    : raw PWM line into the meter
//   largura   : last measured high time (clocks)
//   periodo   : last measured period (clocks)
//   pos       : decoded position of the last valid frame
//   pronto    : one-cycle pulse per closed frame
//   valido    : last closed frame was legal
//   erro      : sticky error (bad frame or timeout)
//   db_estado : FSM state for debug
// master = meter side, slave = consumer / stimulus side.
interface medidor_pwm_if;
  logic        pwm_in;
  logic [31:0] largura;
  logic [31:0] periodo;
  logic [1:0]  pos;
  logic        pronto;
  logic        valido;
  logic        erro;
  logic [1:0]  db_estado;

  modport master (
    input  pwm_in,
    output largura, periodo, pos, pronto, valido, erro, db_estado
  );

  modport slave (
    output pwm_in,
    input  largura, periodo, pos, pronto, valido, erro, db_estado
  );
endinterface

// File: rtl/sincronizador_borda.sv
// Two-flop synchronizer plus one edge register for an asynchronous input.
// Both edge strobes come from the same register pair, so rising and falling
// edges see the same fixed latency and measured intervals are exact.
//   clock   : system clock
//   zera    : asynchronous active-high reset, clears the whole chain
//   entrada : asynchronous input
//   s_sync  : synchronized level
//   subida  : one-cycle strobe on a rising edge
//   descida : one-cycle strobe on a falling edge
module sincronizador_borda (
  input  logic clock,
  input  logic zera,
  input  logic entrada,
  output logic s_sync,
  output logic subida,
  output logic descida
);

  logic s1, s2, s3;

  always_ff @(posedge clock or posedge zera) begin
    if (zera) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= entrada;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign s_sync  = s2;
  assign subida  = s2 & ~s3;
  assign descida = ~s2 & s3;

endmodule

// File: rtl/medidor_pwm.sv
// Servo PWM meter: measures high time and period of the incoming PWM in
// clock cycles and decodes the high time into the 2-bit position code.
//   clock : system clock
//   zera  : asynchronous active-high reset
//   bus   : medidor_pwm_if.master (pwm_in in; measurement results out)
// A frame runs rise-to-rise; it is closed (and reported with pronto) at the
// rise that starts the following frame.
module medidor_pwm
  import medidor_pwm_pkg::*;
#(
  parameter logic [31:0] conf_periodo   = CONF_PERIODO_PADRAO,
  parameter logic [31:0] largura_000    = LARGURA_000_PADRAO,
  parameter logic [31:0] largura_001    = LARGURA_001_PADRAO,
  parameter logic [31:0] largura_010    = LARGURA_010_PADRAO,
  parameter logic [31:0] largura_011    = LARGURA_011_PADRAO,
  parameter logic [31:0] tolerancia     = TOLERANCIA_PADRAO,
  parameter logic [31:0] tol_periodo    = TOL_PERIODO_PADRAO,
  parameter logic [31:0] limite_timeout = LIMITE_TIMEOUT_PADRAO
) (
  input  logic   clock,
  input  logic   zera,
  medidor_pwm_if.master bus
);

  localparam logic [31:0] NOMINAIS [4] = '{largura_000, largura_001,
                                           largura_010, largura_011};

  logic        s_sync;
  logic        subida;
  logic        descida;

  estado_t     estado;
  logic [31:0] cnt;
  logic [31:0] largura_m;
  logic [31:0] largura_reg;
  logic [31:0] periodo_reg;
  logic [1:0]  pos_reg;
  logic        pronto_reg;
  logic        valido_reg;
  logic        erro_reg;

  logic        casa_largura;
  logic        casa_periodo;
  logic [1:0]  codigo;
  logic        timeout;

  sincronizador_borda u_sinc (
    .clock   (clock),
    .zera    (zera),
    .entrada (bus.pwm_in),
    .s_sync  (s_sync),
    .subida  (subida),
    .descida (descida)
  );

  // Nominals are 12500 apart and the window is strictly 6250 wide, so at
  // most one entry can match; the loop just reports which one.
  always_comb begin
    casa_largura = 1'b0;
    codigo       = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (dentro_janela(largura_m, NOMINAIS[i], tolerancia)) begin
        casa_largura = 1'b1;
        codigo       = 2'(i);
      end
    end
    casa_periodo = dentro_janela(cnt, conf_periodo, tol_periodo);
  end

  // A rise in the same cycle as saturation takes precedence over timeout.
  assign timeout = (cnt == limite_timeout) && !subida;

  always_ff @(posedge clock or posedge zera) begin
    if (zera) begin
      estado      <= INICIAL;
      cnt         <= '0;
      largura_m   <= '0;
      largura_reg <= '0;
      periodo_reg <= '0;
      pos_reg     <= 2'b00;
      pronto_reg  <= 1'b0;
      valido_reg  <= 1'b0;
      erro_reg    <= 1'b0;
    end else begin
      pronto_reg <= 1'b0;

      if (subida)
        cnt <= 32'd1;
      else if (cnt < limite_timeout)
        cnt <= cnt + 32'd1;

      case (estado)
        INICIAL: begin
          // A fall seen here belongs to a frame that started before reset.
          if (subida)
            estado <= ALTO;
        end
        ALTO: begin
          if (descida) begin
            largura_m <= cnt;
            estado    <= BAIXO;
          end
        end
        BAIXO: begin
          if (subida) begin
            periodo_reg <= cnt;
            largura_reg <= largura_m;
            pronto_reg  <= 1'b1;
            if (casa_largura && casa_periodo) begin
              pos_reg    <= codigo;
              valido_reg <= 1'b1;
              erro_reg   <= 1'b0;
            end else begin
              valido_reg <= 1'b0;
              erro_reg   <= 1'b1;
            end
            estado <= ALTO;
          end
        end
        default: estado <= INICIAL;
      endcase

      if (timeout) begin
        estado     <= INICIAL;
        valido_reg <= 1'b0;
        erro_reg   <= 1'b1;
      end
    end
  end

  assign bus.largura   = largura_reg;
  assign bus.periodo   = periodo_reg;
  assign bus.pos       = pos_reg;
  assign bus.pronto    = pronto_reg;
  assign bus.valido    = valido_reg;
  assign bus.erro      = erro_reg;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_medidor_pwm.sv
// Bench for medidor_pwm with timing scaled down by 625 (period 1600 clocks,
// nominals 90/110/130/150, window 10, period window 80, timeout 3200) so the
// full scenario runs in a few tens of thousands of cycles.
module tb_medidor_pwm;

  localparam int P    = 1600;
  localparam int TOL  = 10;
  localparam int TP   = 80;
  localparam int TMO  = 3200;
  localparam int NTAB = 14;
  localparam int NRND = 8;

  typedef struct {
    int         high;
    int         period;
    logic [1:0] pos;
    logic       valido;
    logic       erro;
    bit         tab;
  } vec_t;

  logic clock = 1'b0;
  logic zera  = 1'b1;

  medidor_pwm_if bus ();

  medidor_pwm #(
    .conf_periodo   (32'd1600),
    .largura_000    (32'd90),
    .largura_001    (32'd110),
    .largura_010    (32'd130),
    .largura_011    (32'd150),
    .tolerancia     (32'd10),
    .tol_periodo    (32'd80),
    .limite_timeout (32'd3200)
  ) dut (
    .clock (clock),
    .zera  (zera),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_err = 0;
  int         nom [4] = '{90, 110, 130, 150};
  vec_t       exp_q [$];
  vec_t       open_v;
  bit         have_open = 0;
  logic [1:0] m_pos = 2'b00;
  logic       m_valido = 1'b0;
  logic       m_erro = 1'b0;
  vec_t       tab [NTAB];

  // Reference: a frame is good when its width is strictly inside one
  // nominal's window and its period strictly inside the period window.
  function automatic vec_t model(input int h, input int p);
    vec_t r;
    int   k;
    k = -1;
    for (int i = 0; i < 4; i++)
      if ((h > nom[i] ? h - nom[i] : nom[i] - h) < TOL) k = i;
    r.high = h;
    r.period = p;
    r.tab = 0;
    if (k >= 0 && (p > P ? p - P : P - p) < TP) begin
      r.pos = 2'(k); r.valido = 1'b1; r.erro = 1'b0;
    end else begin
      r.pos = m_pos; r.valido = 1'b0; r.erro = 1'b1;
    end
    return r;
  endfunction

  // Called at each rising edge of pwm_in: closes the open frame, opens v.
  task automatic start_frame(input vec_t v);
    vec_t e;
    if (have_open) begin
      e = open_v.tab ? open_v : model(open_v.high, open_v.period);
      e.high = open_v.high;
      e.period = open_v.period;
      m_pos = e.pos; m_valido = e.valido; m_erro = e.erro;
      exp_q.push_back(e);
    end
    open_v = v;
    have_open = 1;
  endtask

  // Entered and left on a falling clock edge.
  task automatic frame(input vec_t v);
    start_frame(v);
    bus.pwm_in = 1'b1;
    repeat (v.high) @(negedge clock);
    bus.pwm_in = 1'b0;
    repeat (v.period - v.high) @(negedge clock);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_largura"}, int'(bus.largura), 0);
    check({tag, "_periodo"}, int'(bus.periodo), 0);
    check({tag, "_pos"}, int'(bus.pos), 0);
    check({tag, "_flags"}, int'({bus.pronto, bus.valido, bus.erro}), 0);
    check({tag, "_estado"}, int'(bus.db_estado), 0);
  endtask

  // Every pronto pulse must match the oldest pending expectation.
  initial begin
    vec_t e;
    forever begin
      @(posedge clock);
      #1;
      if (bus.pronto === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pronto_unexpected: got pronto=1 largura=%0d periodo=%0d, expected no frame close",
                   bus.largura, bus.periodo);
        end else begin
          e = exp_q.pop_front();
          if (bus.largura !== 32'(e.high) || bus.periodo !== 32'(e.period) ||
              bus.pos !== e.pos || bus.valido !== e.valido || bus.erro !== e.erro) begin
            n_err++;
            $display("FAIL frame_close: got largura=%0d periodo=%0d pos=%0d valido=%0b erro=%0b, expected largura=%0d periodo=%0d pos=%0d valido=%0b erro=%0b",
                     bus.largura, bus.periodo, bus.pos, bus.valido, bus.erro,
                     e.high, e.period, e.pos, e.valido, e.erro);
          end else begin
            $display("frame ok: largura=%0d periodo=%0d pos=%0d valido=%0b erro=%0b",
                     e.high, e.period, e.pos, e.valido, e.erro);
          end
        end
      end
    end
  end

  initial begin
    vec_t v;
    tab[0]  = '{110, 1600, 2'd1, 1'b1, 1'b0, 1'b1};
    tab[1]  = '{ 90, 1600, 2'd0, 1'b1, 1'b0, 1'b1};
    tab[2]  = '{130, 1600, 2'd2, 1'b1, 1'b0, 1'b1};
    tab[3]  = '{150, 1600, 2'd3, 1'b1, 1'b0, 1'b1};
    tab[4]  = '{130, 1600, 2'd2, 1'b1, 1'b0, 1'b1};
    tab[5]  = '{120, 1600, 2'd2, 1'b0, 1'b1, 1'b1}; // equidistant: no match
    tab[6]  = '{130, 1600, 2'd2, 1'b1, 1'b0, 1'b1}; // clears erro
    tab[7]  = '{110, 1440, 2'd2, 1'b0, 1'b1, 1'b1}; // short period
    tab[8]  = '{ 99, 1600, 2'd0, 1'b1, 1'b0, 1'b1}; // just inside width window
    tab[9]  = '{100, 1600, 2'd0, 1'b0, 1'b1, 1'b1}; // on width window edge
    tab[10] = '{150, 1679, 2'd3, 1'b1, 1'b0, 1'b1};
    tab[11] = '{150, 1680, 2'd3, 1'b0, 1'b1, 1'b1};
    tab[12] = '{150, 1521, 2'd3, 1'b1, 1'b0, 1'b1};
    tab[13] = '{150, 1520, 2'd3, 1'b0, 1'b1, 1'b1};

    bus.pwm_in = 1'b0;
    zera = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    zera = 1'b0;
    @(negedge clock);

    for (int i = 0; i < NTAB; i++) frame(tab[i]);

    for (int i = 0; i < NRND; i++) begin
      v = '{0, 0, 2'd0, 1'b0, 1'b0, 1'b0};
      v.high = int'($urandom_range(80, 160));
      v.period = int'($urandom_range(1500, 1700));
      frame(v);
    end

    // Loss of signal: one rise, then low well past the timeout.
    v = '{110, 3400, 2'd0, 1'b0, 1'b0, 1'b0};
    frame(v);
    have_open = 0;
    m_valido = 1'b0;
    m_erro = 1'b1;
    check("timeout_estado", int'(bus.db_estado), 0);
    check("timeout_erro", int'(bus.erro), 1);
    check("timeout_valido", int'(bus.valido), 0);
    check("timeout_pos", int'(bus.pos), int'(m_pos));

    // Resume: the first rise only restarts measurement.
    v = '{110, 1600, 2'd0, 1'b0, 1'b0, 1'b0};
    frame(v);
    check("resume_erro_held", int'(bus.erro), 1);
    v = '{130, 1600, 2'd0, 1'b0, 1'b0, 1'b0};
    frame(v);

    // Reset in the middle of a high pulse, released while still high.
    v = '{0, 0, 2'd0, 1'b0, 1'b0, 1'b0};
    start_frame(v);
    bus.pwm_in = 1'b1;
    repeat (30) @(negedge clock);
    zera = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    have_open = 0;
    m_pos = 2'b00; m_valido = 1'b0; m_erro = 1'b0;
    repeat (2) @(negedge clock);
    zera = 1'b0;
    // The cleared chain sees the still-high line as a rise at release.
    v = '{40, 1600, 2'd0, 1'b0, 1'b0, 1'b0};
    start_frame(v);
    repeat (40) @(negedge clock);
    bus.pwm_in = 1'b0;
    repeat (1560) @(negedge clock);
    check("post_reset_estado", int'(bus.db_estado), 2);
    v = '{110, 1600, 2'd0, 1'b0, 1'b0, 1'b0};
    frame(v);
    v = '{130, 1600, 2'd0, 1'b0, 1'b0, 1'b0};
    frame(v);
    v = '{0, 0, 2'd0, 1'b0, 1'b0, 1'b0};
    start_frame(v);
    bus.pwm_in = 1'b1;
    repeat (20) @(negedge clock);

    check("pending_frames", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
